// File: rtl/wb_pkg.sv
// Shared types and defaults for the Wishbone master bridge.
// Holds the FSM state encoding, response codes and width defaults.
package wb_pkg;

    // Default geometry of the bridge
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    // Bridge sequencing: wait for command, run bus cycle, hold response
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    // How a bus cycle ended
    typedef enum logic [1:0] {
        RSP_OK      = 2'd0,
        RSP_BUS_ERR = 2'd1,
        RSP_TIMEOUT = 2'd2
    } rsp_code_t;

    // Any ending other than a clean ack is reported as an error
    function automatic logic is_error(input rsp_code_t code);
        return code != RSP_OK;
    endfunction

endpackage

// File: rtl/wb_master_bridge_if.sv
// Command, response and Wishbone signals of the bridge in one bundle.
// master = the bridge itself, slave = the command source plus bus slave.
interface wb_master_bridge_if
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8
);

    // Command stream
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_we;
    logic [ADDR_WIDTH-1:0]   cmd_adr;
    logic [DATA_WIDTH-1:0]   cmd_dat;
    logic [SELECT_WIDTH-1:0] cmd_sel;

    // Response stream
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_dat;
    logic                    rsp_err;

    // Wishbone classic bus
    logic [ADDR_WIDTH-1:0]   adr_o;
    logic [DATA_WIDTH-1:0]   dat_o;
    logic [DATA_WIDTH-1:0]   dat_i;
    logic                    we_o;
    logic [SELECT_WIDTH-1:0] sel_o;
    logic                    stb_o;
    logic                    cyc_o;
    logic                    ack_i;
    logic                    err_i;

    modport master (
        input  cmd_valid,
        input  cmd_we,
        input  cmd_adr,
        input  cmd_dat,
        input  cmd_sel,
        input  rsp_ready,
        input  dat_i,
        input  ack_i,
        input  err_i,
        output cmd_ready,
        output rsp_valid,
        output rsp_dat,
        output rsp_err,
        output adr_o,
        output dat_o,
        output we_o,
        output sel_o,
        output stb_o,
        output cyc_o
    );

    modport slave (
        output cmd_valid,
        output cmd_we,
        output cmd_adr,
        output cmd_dat,
        output cmd_sel,
        output rsp_ready,
        output dat_i,
        output ack_i,
        output err_i,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_dat,
        input  rsp_err,
        input  adr_o,
        input  dat_o,
        input  we_o,
        input  sel_o,
        input  stb_o,
        input  cyc_o
    );

endinterface

// File: rtl/wb_timeout_counter.sv
// Bus watchdog: counts cycles spent waiting on a slave.
// expired fires in the cycle that completes the allowed budget.
module wb_timeout_counter
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    if (TIMEOUT_CYCLES == 0) begin : g_off

        // Watchdog disabled: a stalled slave stalls the bridge
        logic unused_inputs;
        assign unused_inputs = ^{clk, rst, clear, enable};
        assign expired = 1'b0;

    end else begin : g_on

        localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
        localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

        logic [CW-1:0] count;
        logic [CW-1:0] count_nxt;

        // Saturate at the limit so a long wait never wraps to zero
        assign count_nxt = (count == LIMIT) ? count : count + CW'(1);

        // The current waiting cycle is the one that uses up the budget
        assign expired = enable && (count_nxt == LIMIT);

        // Count waiting cycles, restarting when a new command is taken
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                count <= '0;
            end else if (clear) begin
                count <= '0;
            end else if (enable) begin
                count <= count_nxt;
            end
        end

    end

endmodule

// File: rtl/wb_master_bridge.sv
// Wishbone classic initiator with one outstanding transaction.
// Turns valid/ready commands into single bus cycles and returns results.
module wb_master_bridge
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    wb_master_bridge_if.master bus
);

    state_t    state;
    rsp_code_t code;
    logic      cmd_fire;
    logic      in_bus;
    logic      expired;
    logic      done;

    // Only an idle bridge out of reset takes a command
    assign bus.cmd_ready = (state == IDLE) && !rst;
    assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
    assign in_bus        = (state == BUS);

    wb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (cmd_fire),
        .enable  (in_bus),
        .expired (expired)
    );

    // Classify how the cycle ends; ack beats a simultaneous timeout
    always_comb begin
        code = RSP_OK;
        if (bus.err_i) begin
            code = RSP_BUS_ERR;
        end else if (!bus.ack_i && expired) begin
            code = RSP_TIMEOUT;
        end
    end

    assign done = bus.ack_i || bus.err_i || expired;

    // Bridge sequencer with registered bus and response outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.cyc_o     <= 1'b0;
            bus.stb_o     <= 1'b0;
            bus.we_o      <= 1'b0;
            bus.adr_o     <= '0;
            bus.dat_o     <= '0;
            bus.sel_o     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_dat   <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.adr_o <= ADDR_WIDTH'(bus.cmd_adr);
                        bus.dat_o <= DATA_WIDTH'(bus.cmd_dat);
                        bus.sel_o <= SELECT_WIDTH'(bus.cmd_sel);
                        bus.we_o  <= bus.cmd_we;
                        bus.cyc_o <= 1'b1;
                        bus.stb_o <= 1'b1;
                        state     <= BUS;
                    end
                end
                BUS: begin
                    // Strobe drops on the edge that samples the
                    // termination, so the slave sees one access only
                    if (done) begin
                        bus.cyc_o     <= 1'b0;
                        bus.stb_o     <= 1'b0;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= is_error(code);
                        if (is_error(code) || bus.we_o) begin
                            bus.rsp_dat <= '0;
                        end else begin
                            bus.rsp_dat <= bus.dat_i;
                        end
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge against a small Wishbone RAM.
// A second instance with an 8-cycle watchdog faces a silent slave.
module tb_wb_master_bridge;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wb_master_bridge_if bi ();
    wb_master_bridge_if tif ();

    wb_master_bridge dut (
        .clk (clk),
        .rst (rst),
        .bus (bi)
    );

    wb_master_bridge #(
        .TIMEOUT_CYCLES (8)
    ) dut_to (
        .clk (clk),
        .rst (rst),
        .bus (tif)
    );

    // Word RAM slave: registered ack, optional wait states and errors
    logic [31:0] mem [0:63];
    logic        s_ack;
    logic        s_err;
    logic        stray_ack;
    logic [31:0] s_dat;
    int          stall_cfg;
    int          err_mode;
    int          wcnt;
    int          acks = 0;

    assign bi.ack_i = s_ack | stray_ack;
    assign bi.err_i = s_err;
    assign bi.dat_i = s_dat;

    assign tif.ack_i = 1'b0;
    assign tif.err_i = 1'b0;
    assign tif.dat_i = 32'hFFFF_FFFF;

    // Slave behaviour; responds once per strobe, gated on its own ack
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ack <= 1'b0;
            s_err <= 1'b0;
            s_dat <= '0;
            wcnt  <= 0;
        end else begin
            s_ack <= 1'b0;
            s_err <= 1'b0;
            if (!(bi.cyc_o && bi.stb_o)) begin
                wcnt <= 0;
            end else if (!s_ack && !s_err) begin
                if (wcnt < stall_cfg) begin
                    wcnt <= wcnt + 1;
                end else begin
                    wcnt <= 0;
                    if (err_mode != 0) begin
                        s_err <= 1'b1;
                        if (err_mode == 2) s_ack <= 1'b1;
                    end else begin
                        s_ack <= 1'b1;
                        acks  <= acks + 1;
                        if (bi.we_o) begin
                            for (int b = 0; b < 4; b++)
                                if (bi.sel_o[b])
                                    mem[bi.adr_o[7:2]][8*b +: 8] <= bi.dat_o[8*b +: 8];
                        end else begin
                            s_dat <= mem[bi.adr_o[7:2]];
                        end
                    end
                end
            end
        end
    end

    // One command/response round trip on the RAM-side instance
    task automatic transact(
        input  logic        we,
        input  logic [31:0] adr,
        input  logic [31:0] dat,
        input  logic [3:0]  sel,
        input  int          hold,
        output logic        rdy,
        output int          lat,
        output int          cyc_n,
        output logic [31:0] rdata,
        output logic        rerr,
        output logic        stable
    );
        @(negedge clk);
        rdy = bi.cmd_ready;
        bi.cmd_valid = 1'b1;
        bi.cmd_we    = we;
        bi.cmd_adr   = adr;
        bi.cmd_dat   = dat;
        bi.cmd_sel   = sel;
        @(negedge clk);
        bi.cmd_valid = 1'b0;
        lat   = 1;
        cyc_n = 0;
        while (!bi.rsp_valid && lat < 400) begin
            if (bi.cyc_o) cyc_n++;
            @(negedge clk);
            lat++;
        end
        rdata  = bi.rsp_dat;
        rerr   = bi.rsp_err;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bi.rsp_valid !== 1'b1 || bi.rsp_dat !== rdata ||
                bi.rsp_err !== rerr || bi.cmd_ready !== 1'b0 ||
                bi.cyc_o !== 1'b0)
                stable = 1'b0;
        end
        bi.rsp_ready = 1'b1;
        @(negedge clk);
        bi.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({bi.cyc_o, bi.stb_o, bi.we_o, bi.rsp_valid, bi.rsp_err} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {bi.cyc_o, bi.stb_o, bi.we_o, bi.rsp_valid, bi.rsp_err});
        end
        vectors++;
        if ({bi.adr_o, bi.dat_o, bi.sel_o, bi.rsp_dat} !== 100'b0) begin
            miscompares++;
            $display("FAIL reset_data: adr %h dat %h sel %h rsp %h want 0",
                     bi.adr_o, bi.dat_o, bi.sel_o, bi.rsp_dat);
        end
        vectors++;
        if (bi.cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: got %b want 0", bi.cmd_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bi.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b want 1", bi.cmd_ready);
        end
    endtask

    task automatic test_write_read();
        logic rdy, rerr, st;
        int lat, cn;
        logic [31:0] rd;
        transact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rdy, lat, cn, rd, rerr, st);
        vectors++;
        if ({rdy, rerr, rd} !== {1'b1, 1'b0, 32'h0}) begin
            miscompares++;
            $display("FAIL wr_rsp: rdy %b err %b dat %h want 1 0 0", rdy, rerr, rd);
        end
        vectors++;
        if (lat !== 3) begin
            miscompares++;
            $display("FAIL wr_latency: got %0d want 3", lat);
        end
        transact(1'b0, 32'h10, 32'h0, 4'hF, 0, rdy, lat, cn, rd, rerr, st);
        vectors++;
        if ({rerr, rd} !== {1'b0, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL rd_rsp: err %b dat %h want 0 deadbeef", rerr, rd);
        end
        vectors++;
        if (lat !== 3 || cn !== 2) begin
            miscompares++;
            $display("FAIL rd_timing: lat %0d cyc %0d want 3 2", lat, cn);
        end
    endtask

    task automatic test_byte_select();
        logic rdy, rerr, st;
        int lat, cn;
        logic [31:0] rd;
        transact(1'b1, 32'h20, 32'h11223344, 4'hF, 0, rdy, lat, cn, rd, rerr, st);
        transact(1'b1, 32'h20, 32'hAABBCCDD, 4'h2, 0, rdy, lat, cn, rd, rerr, st);
        transact(1'b0, 32'h20, 32'h0, 4'hF, 0, rdy, lat, cn, rd, rerr, st);
        vectors++;
        if (rd !== 32'h1122CC44) begin
            miscompares++;
            $display("FAIL byte_sel: got %h want 1122cc44", rd);
        end
    endtask

    task automatic test_stall();
        logic rdy, rerr, st;
        int lat, cn, a0;
        logic [31:0] rd;
        stall_cfg = 9;
        a0 = acks;
        transact(1'b0, 32'h10, 32'h0, 4'hF, 0, rdy, lat, cn, rd, rerr, st);
        stall_cfg = 0;
        vectors++;
        if (cn !== 11 || lat !== 12) begin
            miscompares++;
            $display("FAIL stall_cycles: cyc %0d lat %0d want 11 12", cn, lat);
        end
        vectors++;
        if ({rerr, rd} !== {1'b0, 32'hDEADBEEF}) begin
            miscompares++;
            $display("FAIL stall_rsp: err %b dat %h want 0 deadbeef", rerr, rd);
        end
        @(negedge clk);
        vectors++;
        if (acks - a0 !== 1 || bi.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_single_ack: acks %0d rsp_valid %b want 1 0",
                     acks - a0, bi.rsp_valid);
        end
    endtask

    task automatic test_backpressure_err();
        logic rdy, rerr, st;
        int lat, cn;
        logic [31:0] rd;
        err_mode = 1;
        transact(1'b1, 32'h30, 32'h55AA55AA, 4'hF, 5, rdy, lat, cn, rd, rerr, st);
        vectors++;
        if ({rerr, rd} !== {1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL err_rsp: err %b dat %h want 1 0", rerr, rd);
        end
        vectors++;
        if (st !== 1'b1 || lat !== 3) begin
            miscompares++;
            $display("FAIL backpressure_hold: stable %b lat %0d want 1 3", st, lat);
        end
        err_mode = 2;
        transact(1'b0, 32'h10, 32'h0, 4'hF, 0, rdy, lat, cn, rd, rerr, st);
        err_mode = 0;
        vectors++;
        if ({rerr, rd} !== {1'b1, 32'h0}) begin
            miscompares++;
            $display("FAIL err_with_ack: err %b dat %h want 1 0", rerr, rd);
        end
    endtask

    task automatic test_stray_ack();
        @(negedge clk);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        vectors++;
        if ({bi.rsp_valid, bi.cyc_o, bi.cmd_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL idle_ack_ignored: valid/cyc/ready %b want 001",
                     {bi.rsp_valid, bi.cyc_o, bi.cmd_ready});
        end
    endtask

    task automatic test_back_to_back();
        int t, acc, nr;
        int acc_t [2];
        logic [31:0] r [2];
        acc = 0;
        nr  = 0;
        acc_t[0] = 0;
        acc_t[1] = 0;
        r[0] = '0;
        r[1] = '0;
        @(negedge clk);
        bi.rsp_ready = 1'b1;
        bi.cmd_valid = 1'b1;
        bi.cmd_we    = 1'b0;
        bi.cmd_adr   = 32'h10;
        bi.cmd_sel   = 4'hF;
        t = 0;
        while (t < 12) begin
            if (bi.cmd_valid && bi.cmd_ready) begin
                if (acc < 2) acc_t[acc] = t;
                acc++;
            end
            if (bi.rsp_valid) begin
                if (nr < 2) r[nr] = bi.rsp_dat;
                nr++;
            end
            @(negedge clk);
            t++;
            if (acc == 1) bi.cmd_adr = 32'h20;
            if (acc >= 2) bi.cmd_valid = 1'b0;
        end
        bi.rsp_ready = 1'b0;
        bi.cmd_valid = 1'b0;
        vectors++;
        if (acc !== 2 || nr !== 2 || acc_t[1] - acc_t[0] !== 4) begin
            miscompares++;
            $display("FAIL b2b_rate: accepts %0d rsps %0d spacing %0d want 2 2 4",
                     acc, nr, acc_t[1] - acc_t[0]);
        end
        vectors++;
        if (r[0] !== 32'hDEADBEEF || r[1] !== 32'h1122CC44) begin
            miscompares++;
            $display("FAIL b2b_data: got %h %h want deadbeef 1122cc44", r[0], r[1]);
        end
    endtask

    task automatic test_timeout();
        int lat, cn;
        logic rdy;
        @(negedge clk);
        rdy = tif.cmd_ready;
        tif.cmd_valid = 1'b1;
        tif.cmd_we    = 1'b0;
        tif.cmd_adr   = 32'h40;
        tif.cmd_sel   = 4'hF;
        @(negedge clk);
        tif.cmd_valid = 1'b0;
        lat = 1;
        cn  = 0;
        while (!tif.rsp_valid && lat < 400) begin
            if (tif.cyc_o) cn++;
            @(negedge clk);
            lat++;
        end
        vectors++;
        if (rdy !== 1'b1 || cn !== 8 || lat !== 9) begin
            miscompares++;
            $display("FAIL timeout_cycles: rdy %b cyc %0d lat %0d want 1 8 9",
                     rdy, cn, lat);
        end
        vectors++;
        if ({tif.rsp_err, tif.rsp_dat, tif.cyc_o} !== {1'b1, 32'h0, 1'b0}) begin
            miscompares++;
            $display("FAIL timeout_rsp: err %b dat %h cyc %b want 1 0 0",
                     tif.rsp_err, tif.rsp_dat, tif.cyc_o);
        end
        tif.rsp_ready = 1'b1;
        @(negedge clk);
        tif.rsp_ready = 1'b0;
        vectors++;
        if ({tif.rsp_valid, tif.cmd_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL timeout_release: valid/ready %b want 01",
                     {tif.rsp_valid, tif.cmd_ready});
        end
    endtask

    task automatic test_reset_mid_bus();
        logic rdy, rerr, st;
        int lat, cn;
        logic [31:0] rd;
        @(negedge clk);
        bi.cmd_valid = 1'b1;
        bi.cmd_we    = 1'b0;
        bi.cmd_adr   = 32'h20;
        bi.cmd_sel   = 4'hF;
        @(negedge clk);
        bi.cmd_valid = 1'b0;
        vectors++;
        if (bi.stb_o !== 1'b1) begin
            miscompares++;
            $display("FAIL midbus_pre: stb %b want 1", bi.stb_o);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({bi.cyc_o, bi.stb_o, bi.rsp_valid, bi.cmd_ready} !== 4'b0) begin
            miscompares++;
            $display("FAIL midbus_async: cyc/stb/valid/ready %b want 0000",
                     {bi.cyc_o, bi.stb_o, bi.rsp_valid, bi.cmd_ready});
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bi.cmd_ready, bi.cyc_o} !== 2'b10) begin
            miscompares++;
            $display("FAIL midbus_release: ready/cyc %b want 10",
                     {bi.cmd_ready, bi.cyc_o});
        end
        transact(1'b0, 32'h20, 32'h0, 4'hF, 0, rdy, lat, cn, rd, rerr, st);
        vectors++;
        if ({rerr, rd} !== {1'b0, 32'h1122CC44} || lat !== 3) begin
            miscompares++;
            $display("FAIL midbus_after: err %b dat %h lat %0d want 0 1122cc44 3",
                     rerr, rd, lat);
        end
    endtask

    initial begin
        bi.cmd_valid  = 1'b0;
        bi.cmd_we     = 1'b0;
        bi.cmd_adr    = '0;
        bi.cmd_dat    = '0;
        bi.cmd_sel    = '0;
        bi.rsp_ready  = 1'b0;
        tif.cmd_valid = 1'b0;
        tif.cmd_we    = 1'b0;
        tif.cmd_adr   = '0;
        tif.cmd_dat   = '0;
        tif.cmd_sel   = '0;
        tif.rsp_ready = 1'b0;
        stray_ack     = 1'b0;
        stall_cfg     = 0;
        err_mode      = 0;
        #1 rst = 1'b1;
        test_reset();
        test_write_read();
        test_byte_select();
        test_stall();
        test_backpressure_err();
        test_stray_ack();
        test_back_to_back();
        test_timeout();
        test_reset_mid_bus();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
- Wishbone classic initiator: turns a simple valid/ready command stream (from the CPU core or a test driver) into single Wishbone read/write cycles.
- Returns each cycle's result on a valid/ready response stream.
- Sits between the CPU/UART loader and Wishbone slaves such as the on-chip RAM; exactly one outstanding transaction.
- Bus timeout watchdog reports hung slaves instead of stalling forever.

Parameters:
DATA_WIDTH, 32, Wishbone data width in bits (8/16/32/64)
ADDR_WIDTH, 32, Wishbone byte address width
SELECT_WIDTH, DATA_WIDTH/8, byte-select width
TIMEOUT_CYCLES, 255, max cycles waiting for ack/err; 0 disables timeout

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  bridge can accept command
cmd_we  in  1  1=write, 0=read
cmd_adr  in  ADDR_WIDTH  byte address
cmd_dat  in  DATA_WIDTH  write data
cmd_sel  in  SELECT_WIDTH  byte enables
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes response
rsp_dat  out  DATA_WIDTH  read data (0 for writes and errors)
rsp_err  out  1  transaction ended by err_i or timeout
adr_o  out  ADDR_WIDTH  Wishbone ADR_O
dat_o  out  DATA_WIDTH  Wishbone DAT_O
dat_i  in  DATA_WIDTH  Wishbone DAT_I
we_o  out  1  Wishbone WE_O
sel_o  out  SELECT_WIDTH  Wishbone SEL_O
stb_o  out  1  Wishbone STB_O
cyc_o  out  1  Wishbone CYC_O
ack_i  in  1  Wishbone ACK_I
err_i  in  1  Wishbone ERR_I

Behaviour:
- Reset:
  - One clock `clk`; reset `rst` is asynchronous, active-high.
  - While rst is high, all registered outputs are 0: cyc_o, stb_o, we_o, adr_o, dat_o, sel_o, rsp_valid, rsp_dat, rsp_err.
  - State is IDLE and cmd_ready is forced 0.
  - Reset mid-cycle drops cyc_o/stb_o immediately and discards the transaction.
- States: IDLE, BUS, RESP; outputs are registered except cmd_ready.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch adr/dat/sel/we into adr_o/dat_o/sel_o/we_o, set cyc_o=stb_o=1, clear timeout counter, go to BUS.
- BUS:
  - cyc_o=stb_o=1; cmd_ready=0; counter increments each cycle.
  - ack_i=1: capture rsp_dat=dat_i for reads (0 for writes); rsp_err=0; drop cyc_o/stb_o next edge; rsp_valid=1; go to RESP.
  - err_i=1 (with or without ack_i): rsp_err=1, rsp_dat=0, drop cyc/stb, go to RESP.
  - Counter reaches TIMEOUT_CYCLES with no ack/err (TIMEOUT_CYCLES>0): same as err_i.
  - ack_i and timeout expiry on the same cycle: ack wins.
- The strobe is held exactly until the cycle ack_i is sampled, so a slave that gates on ~ack_o never sees a second access.
- RESP:
  - rsp_valid=1 and outputs stable until rsp_ready.
  - On rsp_valid&rsp_ready: rsp_valid=0, go to IDLE.
  - cmd_ready stays 0, so no command/response overlap.
- Zero-wait-state slave with ack one cycle after strobe:
  - command accepted in cycle N;
  - cyc/stb high in N+1..N+2;
  - ack sampled in N+2;
  - rsp_valid high from N+3.
  - Back-to-back throughput is one transaction per 4 cycles with rsp_ready tied high.
- ack_i/err_i outside BUS are ignored.
- we_o/adr_o/dat_o/sel_o keep their last values after the cycle; they are don't-care when cyc_o=0.
- Counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates; it never wraps.

Decomposition:
- Shared package wb_pkg: state enum constants (IDLE/BUS/RESP), response error codes, default width constants.
- One sub-module: wb_timeout_counter.
  - Inputs: clear, enable.
  - Output: expired.
  - Parameter: TIMEOUT_CYCLES; 0 ties expired low.

Test Plan:
- Write then read via wb_ram:
  - Stimulus: cmd write adr=0x10, dat=0xDEADBEEF, sel=0xF, then read adr=0x10.
  - Required: rsp_dat=0xDEADBEEF, rsp_err=0; rsp_valid 3 cycles after each accept.
- Byte-select write:
  - Stimulus: write 0x11223344 to adr 0x20, then write 0xAABBCCDD with sel=0x2.
  - Required: read returns 0x1122CC44.
- Slave stall:
  - Stimulus: ack_i held low 10 cycles.
  - Required: cyc_o/stb_o stay high exactly 11 cycles, no second ack accepted; then normal response.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, ack_i never asserted.
  - Required: cyc_o drops after 8 BUS cycles; rsp_err=1, rsp_dat=0.
- Response backpressure and err:
  - Stimulus: rsp_ready low 5 cycles; err_i pulse on a write.
  - Required: rsp_valid/rsp_dat stable and cmd_ready=0 until handshake; err_i yields rsp_err=1.
- Reset mid-BUS:
  - Stimulus: assert rst asynchronously while stb_o=1.
  - Required: cyc_o, stb_o, rsp_valid go 0 without a clock edge; after release cmd_ready=1 and the next read completes normally.
